// File: rtl/mux_sel_serializer.sv
// Sequencer that serializes an n-bit word LSB first by stepping the select of an
// external n:1 single-bit mux and registering its output.

module mux_generic_1bit #(
  parameter int n = 4
) (
  input  logic [n-1:0]         w,
  input  logic [$clog2(n)-1:0] sel,
  output logic                 f
);
  localparam int SW = $clog2(n);

  // Compare-per-input keeps out-of-range selects harmless for non-power-of-two n.
  always_comb begin
    f = 1'b0;
    for (int i = 0; i < n; i++)
      if (sel == SW'(i)) f = w[i];
  end
endmodule

module mux_sel_serializer #(
  parameter int n = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [n-1:0]         din,
  output logic [n-1:0]         w,
  output logic [$clog2(n)-1:0] sel,
  input  logic                 f,
  output logic                 sout,
  output logic                 sout_valid,
  output logic                 busy,
  output logic                 done
);
  localparam int SW = $clog2(n);
  localparam logic [SW-1:0] LAST = SW'(n - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      w          <= '0;
      sel        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sout_valid <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            w     <= din;
            sel   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sout       <= f;
          sout_valid <= 1'b1;
          if (sel != LAST) begin
            sel  <= sel + 1'b1;
            done <= 1'b0;
          end else begin
            done <= 1'b1;
            // Explicit reload: sel never relies on counter overflow to reach 0.
            if (start) begin
              w   <= din;
              sel <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
